// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding, operation codes and the digit-counter width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of the digit index; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int num_digits);
    if (num_digits <= 1) begin
      return 1;
    end else begin
      return $clog2(num_digits);
    end
  endfunction

endpackage

// File: rtl/serial_adder_subtractor_digit_adder.sv
// DIGIT-wide ripple adder built from full_adder cells. Besides the sum and
// the carry out it exposes the carry into the top bit so the caller can
// detect signed overflow on the most significant digit.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_s[i]),
      .s    (sum[i]),
      .cout (c_s[i+1])
    );
  end

  assign cout  = c_s[DIGIT];
  assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per cycle; the result and flags are valid
// NUM_DIGITS cycles after the operands are accepted.
// Optional feature macro: SERIAL_ADDSUB_SATURATE_EN (saturate on signed
// overflow; carry_out/overflow still describe the unsaturated sum).
module serial_adder_subtractor
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_x,
  input  logic [WIDTH-1:0] input_y,
  input  logic             operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] final_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);
`ifdef SERIAL_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] x_r, y_r, result_r;
  logic [CNT_W-1:0] idx_r;
  logic             carry_r, carry_out_r, overflow_r, zero_r;

  logic             load_s, step_s, last_s, in_ready_s;
  logic [DIGIT-1:0] x_dig_s, y_dig_s, sum_s;
  logic             cout_s, c_msb_s, overflow_s;
  logic [WIDTH-1:0] result_next_s, result_fin_s;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, handshake and datapath enables.
  always_comb begin
    state_s    = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          load_s  = 1'b1;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        // Accepting a new operation in the same cycle as the result leaves
        // keeps back-to-back operations free of bubbles.
        in_ready_s = out_ready;
        if (out_ready && in_valid) begin
          load_s  = 1'b1;
          state_s = BUSY;
        end else if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign last_s = (idx_r == LAST_IDX);

  // Select the current digit of both latched operands.
  always_comb begin
    x_dig_s = {DIGIT{1'b0}};
    y_dig_s = {DIGIT{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      x_dig_s = x_dig_s | ((idx_r == CNT_W'(i)) ? x_r[i*DIGIT +: DIGIT] : {DIGIT{1'b0}});
      y_dig_s = y_dig_s | ((idx_r == CNT_W'(i)) ? y_r[i*DIGIT +: DIGIT] : {DIGIT{1'b0}});
    end
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a     (x_dig_s),
    .b     (y_dig_s),
    .cin   (carry_r),
    .sum   (sum_s),
    .cout  (cout_s),
    .c_msb (c_msb_s)
  );

  // Only meaningful on the most significant digit.
  assign overflow_s = c_msb_s ^ cout_s;

  // Merge the new digit into the partially built result.
  always_comb begin
    result_next_s = result_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      result_next_s[i*DIGIT +: DIGIT] =
        (idx_r == CNT_W'(i)) ? sum_s : result_r[i*DIGIT +: DIGIT];
    end
  end

  // Final result value, clamped to the signed limit when saturation is built in.
  always_comb begin
    result_fin_s = result_next_s;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    // On overflow both effective operands share an MSB, so X's MSB gives the direction.
    if (overflow_s) begin
      result_fin_s = x_r[WIDTH-1] ? SAT_NEG : SAT_POS;
    end else begin
      result_fin_s = result_next_s;
    end
`endif
  end

  // Operand capture, digit iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      idx_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else if (load_s) begin
      // Subtraction is X + ~Y + 1: invert Y here and seed the carry with the op.
      x_r     <= input_x;
      y_r     <= input_y ^ {WIDTH{operation}};
      carry_r <= operation;
      idx_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      carry_r <= cout_s;
      idx_r   <= idx_r + CNT_W'(1);
      if (last_s) begin
        result_r    <= result_fin_s;
        carry_out_r <= cout_s;
        overflow_r  <= overflow_s;
        zero_r      <= ~|result_fin_s;
      end else begin
        result_r    <= result_next_s;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = (state_r == DONE);
  assign final_result = result_r;
  assign carry_out    = carry_out_r;
  assign overflow     = overflow_r;
  assign zero         = zero_r;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor (WIDTH=16, DIGIT=4).
// Expected values are hand-computed; saturated expectations apply when
// SERIAL_ADDSUB_SATURATE_EN is defined.
module tb_serial_adder_subtractor;
  import serial_addsub_pkg::*;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NUM_DIGITS = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] input_x = 16'h0000;
  logic [WIDTH-1:0] input_y = 16'h0000;
  logic             operation = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] final_result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_x      (input_x),
    .input_y      (input_y),
    .operation    (operation),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .final_result (final_result),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble the inputs to show they
  // are not re-sampled. Leaves the caller #1 after the accepting edge.
  task automatic accept_op(input logic [15:0] x, input logic [15:0] y, input logic op);
    @(negedge clk);
    input_x   = x;
    input_y   = y;
    operation = op;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    input_x   = 16'hA5A5;
    input_y   = 16'h5A5A;
    operation = ~op;
  endtask

  // Wait out the serial latency, checking out_valid rises exactly on the last digit.
  task automatic wait_result(input string tag);
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      @(posedge clk);
      #1;
      check_eq({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, (k == NUM_DIGITS)});
      if (k == 1) check_eq({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] res,
                              input logic c, input logic v, input logic z);
    check_eq({tag, " result"}, {16'd0, final_result}, {16'd0, res});
    check_eq({tag, " carry"}, {31'd0, carry_out}, {31'd0, c});
    check_eq({tag, " overflow"}, {31'd0, overflow}, {31'd0, v});
    check_eq({tag, " zero"}, {31'd0, zero}, {31'd0, z});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, " released"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, " idle ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic op, input logic [15:0] res,
                        input logic c, input logic v, input logic z);
    accept_op(x, y, op);
    wait_result(tag);
    check_result(tag, res, c, v, z);
    release_result(tag);
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 16'h1234, 16'h0FFF, OP_ADD, 16'h2233, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    run_op("pos_ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 16'h8000, 16'h0001, OP_SUB, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    run_op("pos_ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    run_op("borrow", 16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("zero_sub", 16'h0000, 16'h0000, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("wrap_add", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("mixed_sub", 16'h1234, 16'h0235, OP_SUB, 16'h0FFF, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held while out_ready=0, in_valid ignored
    accept_op(16'h0003, 16'h0004, OP_ADD);
    wait_result("bp");
    @(negedge clk);
    in_valid = 1'b1;
    input_x  = 16'h0100;
    input_y  = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_eq("bp hold valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp hold result", {16'd0, final_result}, 32'h0000_0007);
      check_eq("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    // Back-to-back: release result and accept new operands on one edge
    @(negedge clk);
    input_x   = 16'h0001;
    input_y   = 16'h0001;
    operation = OP_ADD;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("b2b in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    input_x   = 16'hFFFF;
    check_eq("b2b busy", {31'd0, out_valid}, 32'd0);
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      @(posedge clk);
      #1;
      check_eq("b2b out_valid", {31'd0, out_valid}, {31'd0, (k == NUM_DIGITS)});
    end
    check_result("b2b", 16'h0002, 1'b0, 1'b0, 1'b0);
    release_result("b2b");

    // Reset during BUSY digit 2: partial result must vanish without a clock
    accept_op(16'h1111, 16'h2222, OP_ADD);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check_result("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check_eq("post rst no valid", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst", 16'h1111, 16'h2222, OP_ADD, 16'h3333, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor; next generation of the team's 4-bit ripple add/sub.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for area on wide operands.
- Adds valid/ready handshakes on input and output, plus registered carry, overflow and zero flags.
- Sits between the operand register file and the result bus in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; NUM_DIGITS = WIDTH/DIGIT, must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and operation valid.
- in_ready  output  1  block can accept operands.
- input_x  input  WIDTH  operand X.
- input_y  input  WIDTH  operand Y.
- operation  input  1  0 = X+Y, 1 = X−Y.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- final_result  output  WIDTH  sum/difference.
- carry_out  output  1  final carry; for subtract, 1 = no borrow (X ≥ Y unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  final_result == 0.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, final_result=0, carry_out=0, overflow=0, zero=0; digit counter and carry register cleared.
- Reset mid-operation: the operation in flight is discarded with no partial output; state returns to IDLE immediately.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, latch input_x, latch input_y XOR {WIDTH{operation}}, load the carry register with operation, set digit index to 0, go to BUSY.
- BUSY: in_ready=0. Each cycle, add digit[idx] of X and the modified Y plus the carry register; write the DIGIT-bit sum into final_result digit idx and update the carry register.
  - On the last digit, record carry_out as the carry out of the MSB.
  - Record overflow as the carry into the MSB XOR the carry out of the MSB.
  - Compute zero from the complete result; go to DONE.
- Latency: out_valid rises exactly NUM_DIGITS cycles after the accepting edge. For WIDTH=16, DIGIT=4 that is 4 cycles.
- DONE: out_valid=1; final_result and flags are held stable until the out_ready handshake.
  - in_ready = out_ready, which allows back-to-back operations.
  - out_ready=1 and in_valid=1: complete the handshake, accept new operands, go to BUSY with no bubble cycle.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=0: stay in DONE and ignore in_valid.
- Intermediate values: final_result digits above idx may hold stale data while BUSY; consumers sample only when out_valid=1.
- Input sampling: input_x, input_y and operation are sampled only on the accepting edge; later changes have no effect.
- Wrap-around: without saturation, results are modulo 2^WIDTH.

Optional Feature:
- Macro: SERIAL_ADDSUB_SATURATE_EN.
- Defined: when overflow=1, final_result saturates to the signed limit.
  - Positive overflow (both effective operands' MSBs = 0) gives 0x7FFF…; negative overflow gives 0x8000….
  - carry_out and overflow report the unsaturated operation.
  - zero is evaluated on the saturated value.
- Undefined: results wrap; no saturation logic is synthesised.

Decomposition:
- Shared package serial_addsub_pkg:
  - FSM state enum (IDLE/BUSY/DONE).
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - Function computing the digit-counter width, clog2(NUM_DIGITS) with minimum 1.
- One sub-module, digit_adder: a DIGIT-wide ripple of the existing full_adder cells.
  - Outputs: sum, carry out, and carry into the top bit (for overflow detection).

Test Plan (WIDTH=16, DIGIT=4):
- Add: X=0x1234, Y=0x0FFF, op=0 → out_valid 4 cycles after accept; result=0x2233, carry_out=0, overflow=0, zero=0.
- Signed overflow: X=0x7FFF, Y=0x0001, op=0 → 0x8000, overflow=1; with SERIAL_ADDSUB_SATURATE_EN → 0x7FFF, overflow=1.
- Borrow and negative overflow:
  - X=0x0005, Y=0x0007, op=1 → 0xFFFE, carry_out=0, overflow=0.
  - X=0x8000, Y=0x0001, op=1 → 0x7FFF, overflow=1 (saturated: 0x8000).
- Zero: X=0x0000, Y=0x0000, op=1 → 0x0000, carry_out=1, zero=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE → result stable and in_ready=0.
  - Then out_ready=1 with in_valid=1 (0x0001+0x0001) → accepted the same cycle; next result 0x0002 after 4 cycles.
- Reset mid-operation: assert rst_n=0 during BUSY digit 2 → all outputs 0 and in_ready=1 asynchronously; after release, no stale out_valid appears.
